// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO controller slice.
// Pointer and count widths derive from ADDR_WIDTH.
package fifo_pkg;

  localparam int DATA_WIDTH = 10;
  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;

  // Extra MSB is the wrap bit that separates full from empty.
  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH:0]   count_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
    return (wr[ADDR_WIDTH-1:0] == rd[ADDR_WIDTH-1:0]) &&
           (wr[ADDR_WIDTH] != rd[ADDR_WIDTH]);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register with increment enable.
// Synchronous active-high reset to zero.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [AW:0] ptr
);

  localparam logic [AW:0] ONE = 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ONE;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port memory.
// FIFO_CTRL_ALMOST_EN enables registered almost_full/almost_empty.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH        = fifo_pkg::DEPTH,
  parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam logic [ADDR_WIDTH:0] ONE = 1;

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_nxt;
  logic                push_ok;
  logic                pop_ok;
  logic                err_set;

  fifo_ptr #(.AW(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.AW(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // A push while full stays rejected even with a same-cycle pop.
  assign push_ok = push & ~full & ~reset;
  assign pop_ok  = pop & ~empty & ~reset;
  assign err_set = (push & full) | (pop & empty);

  assign mem_wr_en   = push_ok;
  assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_wr_data = data_in;
  assign mem_rd_en   = pop_ok;
  assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign data_out    = mem_rd_data;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      (push_ok & ~pop_ok): count_nxt = count + ONE;
      (pop_ok & ~push_ok): count_nxt = count - ONE;
      default:             count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      fifo_error <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      count      <= count_nxt;
      fifo_error <= fifo_error | err_set;
      data_valid <= pop_ok;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_TH = ALMOST_FULL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH = ALMOST_EMPTY[ADDR_WIDTH:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= AF_TH);
      almost_empty <= (count_nxt <= AE_TH);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
